// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the EX-stage ALU control: Operation codes, ALUOp classes,
// RV32M op / sequencer state enums and the non-M decode table.
package riscv_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Ordered so that a Funct3 value casts directly to the matching M op
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;

    function automatic logic [3:0] alu_decode(input logic [2:0] aluop,
                                              input logic [6:0] f7,
                                              input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: op = ALU_SUB;
                    3'b100, 3'b101: op = ALU_SLT;
                    3'b110, 3'b111: op = ALU_SLTU;
                    default:        op = ALU_ADD;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                // R-type only accepts funct7 0000000, or 0100000 for SUB/SRA
                if (aluop == ALUOP_ITYPE || f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    case (f3)
                        3'b000: op = (aluop == ALUOP_RTYPE && f7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001: op = ALU_SLL;
                        3'b010: op = ALU_SLT;
                        3'b011: op = ALU_SLTU;
                        3'b100: op = ALU_XOR;
                        3'b101: op = f7[5] ? ALU_SRA : ALU_SRL;
                        3'b110: op = ALU_OR;
                        3'b111: op = ALU_AND;
                    endcase
                end
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide datapath: one shared 2*XLEN accumulator plus an operand
// register, stepped as shift-add (MUL_BPC bits/cycle) or restoring shift-subtract.
module mdu_iter_core #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [XLEN-1:0]     load_lo,
    input  logic [XLEN-1:0]     load_m,
    input  logic                mul_step,
    input  logic                div_step,
    output logic [2*XLEN-1:0]   acc_d
);

    logic [2*XLEN-1:0]       acc_q;
    logic [XLEN-1:0]         m_q;
    logic [XLEN+MUL_BPC-1:0] mul_sum;
    logic [XLEN:0]           div_shift;
    logic [XLEN-1:0]         div_sub;
    logic                    div_ge;

    // Upper half accumulates partial products (mul) or holds the remainder (div);
    // lower half holds the multiplier or the dividend/quotient shift register.
    always_comb begin
        mul_sum = {{MUL_BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        for (int i = 0; i < MUL_BPC; i++) begin
            if (acc_q[i]) begin
                mul_sum = mul_sum + ({{MUL_BPC{1'b0}}, m_q} << i);
            end
        end
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, m_q};
        div_sub   = div_shift[XLEN-1:0] - m_q;
        acc_d     = acc_q;
        if (load) begin
            acc_d = {{XLEN{1'b0}}, load_lo};
        end else if (mul_step) begin
            acc_d = {mul_sum, acc_q[XLEN-1:MUL_BPC]};
        end else if (div_step) begin
            acc_d = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (load) begin
                m_q <= load_m;
            end
        end
    end

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU control with RV32M: combinational ALU decode, plus an iterative
// multiply/divide sequencer that stalls the pipeline until its result is ready.
module alu_mdu_controller
    import riscv_alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_BPC  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [3:0]      Operation,
    output logic            md_sel_o,
    output logic [XLEN-1:0] md_result_o,
    output logic            md_done_o,
    output logic            stall_o,
    output logic            illegal_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_in, op_q;
    logic              sa, sb, sa_q, sb_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, iter_res, result_q, quo, rem;
    logic [2*XLEN-1:0] acc_d, prod;
    logic              is_m, start, is_div, a_signed, b_signed, div0, ovf, special;
    logic              load, mul_step, div_step, finish_iter;

    assign is_m        = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
    assign Operation   = is_m ? ALU_ADD : alu_decode(ALUOp, Funct7, Funct3);
    assign md_sel_o    = is_m && ENABLE_M;
    assign illegal_o   = is_m && !ENABLE_M;
    assign start       = (state_q == ST_IDLE) && valid_i && is_m && ENABLE_M && !flush_i;
    assign md_result_o = result_q;

    // Operand conditioning in the start cycle; special cases bypass the sequencer
    always_comb begin
        op_in    = md_op_e'(Funct3);
        is_div   = Funct3[2];
        a_signed = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_signed = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        sa       = a_signed && rs1_i[XLEN-1];
        sb       = b_signed && rs2_i[XLEN-1];
        a_mag    = sa ? -rs1_i : rs1_i;
        b_mag    = sb ? -rs2_i : rs2_i;
        div0     = is_div && (rs2_i == '0);
        ovf      = is_div && b_signed && (rs1_i == INT_MIN) && (rs2_i == '1);
        special  = div0 || ovf;
        if (div0) begin
            special_res = Funct3[1] ? rs1_i : '1;
        end else begin
            special_res = Funct3[1] ? '0 : rs1_i;
        end
    end

    // Sign fix-up is taken from the accumulator value written on the final step
    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc_d : acc_d;
        quo  = acc_d[XLEN-1:0];
        rem  = acc_d[2*XLEN-1:XLEN];
        if (state_q == ST_MUL) begin
            iter_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            iter_res = sa_q ? -rem : rem;
        end else begin
            iter_res = (sa_q ^ sb_q) ? -quo : quo;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_o     = 1'b0;
        md_done_o   = 1'b0;
        load        = 1'b0;
        mul_step    = 1'b0;
        div_step    = 1'b0;
        finish_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    load    = 1'b1;
                    cnt_d   = is_div ? CW'(XLEN - 1) : CW'(XLEN / MUL_BPC - 1);
                    if (special) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = is_div ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                stall_o  = 1'b1;
                mul_step = (state_q == ST_MUL);
                div_step = (state_q == ST_DIV);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    finish_iter = !flush_i;
                end
            end
            ST_DONE: begin
                md_done_o = !flush_i;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                op_q <= op_in;
                sa_q <= sa;
                sb_q <= sb;
            end
            if (start && special) begin
                result_q <= special_res;
            end else if (finish_iter) begin
                result_q <= iter_res;
            end
        end
    end

    mdu_iter_core #(
        .XLEN    (XLEN),
        .MUL_BPC (MUL_BPC)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_lo  (is_div ? a_mag : b_mag),
        .load_m   (is_div ? b_mag : a_mag),
        .mul_step (mul_step),
        .div_step (div_step),
        .acc_d    (acc_d)
    );

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench for alu_mdu_controller: decode table, M-op result/latency table,
// and hand-written flush, mid-op reset and ENABLE_M=0 sequences.
module tb_alu_mdu_controller;
    import riscv_alu_pkg::*;

    typedef struct {
        logic [2:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] expOp;
    } decVec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          lat;
        int          which;
    } mdVec_t;

    logic        clk, reset, valid_i, flush_i;
    logic [2:0]  ALUOp, Funct3;
    logic [6:0]  Funct7;
    logic [31:0] rs1_i, rs2_i;

    logic [3:0]  opA, opB, opC, selOp;
    logic        selA, selB, selC, selSel;
    logic [31:0] resA, resB, resC, selRes;
    logic        doneA, doneB, doneC, selDone;
    logic        stallA, stallB, stallC, selStall;
    logic        illA, illB, illC, selIll;

    int sel;
    int compared;
    int mismatched;

    decVec_t decTab [8];
    mdVec_t  mdTab [14];

    alu_mdu_controller #(.XLEN(32), .ENABLE_M(1'b1), .MUL_BPC(1)) dutA (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .Operation(opA), .md_sel_o(selA), .md_result_o(resA), .md_done_o(doneA),
        .stall_o(stallA), .illegal_o(illA));

    alu_mdu_controller #(.XLEN(32), .ENABLE_M(1'b1), .MUL_BPC(4)) dutB (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .Operation(opB), .md_sel_o(selB), .md_result_o(resB), .md_done_o(doneB),
        .stall_o(stallB), .illegal_o(illB));

    alu_mdu_controller #(.XLEN(32), .ENABLE_M(1'b0), .MUL_BPC(1)) dutC (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .Operation(opC), .md_sel_o(selC), .md_result_o(resC), .md_done_o(doneC),
        .stall_o(stallC), .illegal_o(illC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                selOp = opB; selSel = selB; selRes = resB;
                selDone = doneB; selStall = stallB; selIll = illB;
            end
            2: begin
                selOp = opC; selSel = selC; selRes = resC;
                selDone = doneC; selStall = stallC; selIll = illC;
            end
            default: begin
                selOp = opA; selSel = selA; selRes = resA;
                selDone = doneA; selStall = stallA; selIll = illA;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic v);
        ALUOp   = aluop;
        Funct7  = f7;
        Funct3  = f3;
        rs1_i   = a;
        rs2_i   = b;
        valid_i = v;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue an M op for one cycle (T); returns at the negedge of cycle T+1
    task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(ALUOP_RTYPE, FUNCT7_MULDIV, f3, a, b, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic runMd(input mdVec_t v);
        int lat;
        int stallCnt;
        sel = v.which;
        doReset();
        applyStimulus(ALUOP_RTYPE, FUNCT7_MULDIV, v.f3, v.a, v.b, 1'b1);
        #1;
        checkOutput("stallInT", 64'(selStall), 64'd1);
        checkOutput("mdSelM", 64'(selSel), 64'd1);
        checkOutput("opForM", 64'(selOp), 64'(ALU_ADD));
        @(negedge clk);
        valid_i  = 1'b0;
        lat      = 0;
        stallCnt = 1;
        for (int n = 1; n <= 100; n++) begin
            if (selDone) begin
                lat = n;
                break;
            end
            if (selStall) stallCnt++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(lat), 64'(v.lat));
        checkOutput("stallCycles", 64'(stallCnt), 64'(v.lat));
        checkOutput("result", 64'(selRes), 64'(v.expRes));
        checkOutput("stallAtDone", 64'(selStall), 64'd0);
        @(negedge clk);
        checkOutput("donePulseWidth", 64'(selDone), 64'd0);
        checkOutput("resultHeld", 64'(selRes), 64'(v.expRes));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneSeen;
        int stallSeen;
        compared   = 0;
        mismatched = 0;
        sel        = 0;
        reset      = 1'b1;
        flush_i    = 1'b0;
        applyStimulus(3'b000, 7'b0, 3'b000, 32'h0, 32'h0, 1'b0);

        decTab[0] = '{ALUOP_RTYPE,  7'b0000000, 3'b000, ALU_ADD};
        decTab[1] = '{ALUOP_RTYPE,  7'b0100000, 3'b000, ALU_SUB};
        decTab[2] = '{ALUOP_RTYPE,  7'b0000000, 3'b110, ALU_OR};
        decTab[3] = '{ALUOP_ITYPE,  7'b0000000, 3'b100, ALU_XOR};
        decTab[4] = '{ALUOP_RTYPE,  7'b0000000, 3'b010, ALU_SLT};
        decTab[5] = '{ALUOP_BRANCH, 7'b0000000, 3'b000, ALU_SUB};
        decTab[6] = '{ALUOP_RTYPE,  7'b0100000, 3'b110, ALU_ADD};
        decTab[7] = '{ALUOP_ADD,    7'b0000000, 3'b010, ALU_ADD};

        mdTab[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0};
        mdTab[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0};
        mdTab[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  9, 1};
        mdTab[3]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB,  9, 1};
        mdTab[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, 0};
        mdTab[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 0};
        mdTab[6]  = '{3'b101, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  1, 0};
        mdTab[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,  1, 0};
        mdTab[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, 0};
        mdTab[9]  = '{3'b111, 32'd100,        32'd7,          32'd2,         33, 0};
        mdTab[10] = '{3'b001, 32'h8000_0000, 32'd2,          32'hFFFF_FFFF, 33, 0};
        mdTab[11] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0};
        mdTab[12] = '{3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0};
        mdTab[13] = '{3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         33, 0};

        @(negedge clk);
        checkOutput("resetStall", 64'(stallA), 64'd0);
        checkOutput("resetDone", 64'(doneA), 64'd0);
        checkOutput("resetResult", 64'(resA), 64'd0);
        reset = 1'b0;

        $display("[TB] non-M decode sweep");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(decTab[i].aluop, decTab[i].f7, decTab[i].f3, 32'h5, 32'h3, 1'b1);
            #1;
            checkOutput($sformatf("decOp[%0d]", i), 64'(opA), 64'(decTab[i].expOp));
            checkOutput($sformatf("decSel[%0d]", i), 64'(selA), 64'd0);
            checkOutput($sformatf("decStall[%0d]", i), 64'(stallA), 64'd0);
            checkOutput($sformatf("decIll[%0d]", i), 64'(illA), 64'd0);
            @(negedge clk);
            checkOutput($sformatf("decStallNext[%0d]", i), 64'(stallA), 64'd0);
        end
        valid_i = 1'b0;
        @(negedge clk);

        $display("[TB] M-op table");
        for (int i = 0; i < 14; i++) begin
            runMd(mdTab[i]);
        end

        $display("[TB] flush mid-DIV");
        sel = 0;
        doReset();
        startOp(3'b101, 32'd5, 32'd0);
        @(negedge clk);
        startOp(3'b100, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        checkOutput("stallBeforeFlush", 64'(stallA), 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        checkOutput("stallAfterFlush", 64'(stallA), 64'd0);
        checkOutput("doneAfterFlush", 64'(doneA), 64'd0);
        doneSeen  = 0;
        stallSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneA) doneSeen++;
            if (stallA) stallSeen++;
        end
        checkOutput("noDoneAfterFlush", 64'(doneSeen), 64'd0);
        checkOutput("noStallAfterFlush", 64'(stallSeen), 64'd0);
        checkOutput("resultKeptFlush", 64'(resA), 64'hFFFF_FFFF);

        $display("[TB] async reset mid-MUL");
        startOp(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (4) @(negedge clk);
        checkOutput("stallBeforeReset", 64'(stallA), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("stallInReset", 64'(stallA), 64'd0);
        checkOutput("resultInReset", 64'(resA), 64'd0);
        checkOutput("doneInReset", 64'(doneA), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        doneSeen = 0;
        stallSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneA) doneSeen++;
            if (stallA) stallSeen++;
        end
        checkOutput("noResumeDone", 64'(doneSeen), 64'd0);
        checkOutput("noResumeStall", 64'(stallSeen), 64'd0);

        $display("[TB] ENABLE_M=0");
        sel = 2;
        applyStimulus(ALUOP_RTYPE, FUNCT7_MULDIV, 3'b000, 32'd7, 32'd3, 1'b1);
        #1;
        checkOutput("illegalM", 64'(selIll), 64'd1);
        checkOutput("noStallDisabled", 64'(selStall), 64'd0);
        checkOutput("illegalEnabledDut", 64'(illA), 64'd0);
        stallSeen = 0;
        doneSeen  = 0;
        repeat (3) begin
            @(negedge clk);
            if (selStall) stallSeen++;
            if (selDone) doneSeen++;
        end
        checkOutput("disabledStallCycles", 64'(stallSeen), 64'd0);
        checkOutput("disabledDone", 64'(doneSeen), 64'd0);
        valid_i = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
